// File: rtl/spi_master_p.sv
// Parametrised SPI master: configurable width, divider, chip selects and hold time,
// runtime CPOL/CPHA, full-duplex capture and optional CS-held burst transfers.
module spi_master_p #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CLK_DIV   = 16,
    parameter int unsigned CS_NUM    = 1,
    parameter int unsigned CS_W      = 1,
    parameter int unsigned HOLD_CYC  = 4,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic [CS_W-1:0]   cs_sel_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              cont_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic [CS_NUM-1:0] cs_n_o
);

    localparam int unsigned CNT_MAX = (2 * CLK_DIV > HOLD_CYC) ? 2 * CLK_DIV : HOLD_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned BIT_W   = $clog2(DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                cont_q, cont_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic [CS_NUM-1:0]   cs_n_q, cs_n_d;
    logic                accept;

    function automatic logic [CS_NUM-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [CS_NUM-1:0] v;
        v = '1;
        for (int unsigned i = 0; i < CS_NUM; i++) begin
            if (sel == CS_W'(i)) v[i] = 1'b0;
        end
        return v;
    endfunction

    function automatic logic first_bit(input logic [DATA_W-1:0] x);
        return LSB_FIRST ? x[0] : x[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] x);
        return LSB_FIRST ? (x >> 1) : (x << 1);
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] x, input logic b);
        return LSB_FIRST ? {b, x[DATA_W-1:1]} : {x[DATA_W-2:0], b};
    endfunction

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            cont_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b1;
            cs_n_q    <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            cont_q    <= cont_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        cont_d    = cont_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        accept    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sclk_d = cpol_q;
                accept = start_i;
            end
            ST_SETUP: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    sclk_d = ~cpol_q;
                    if (cpha_q) begin
                        mosi_d = first_bit(tx_q);
                        tx_d   = shift_out(tx_q);
                    end else begin
                        rx_sh_d = shift_in(rx_sh_q, miso_i);
                    end
                end else if (cnt_q == CNT_W'(2 * CLK_DIV - 1)) begin
                    sclk_d = cpol_q;
                    cnt_d  = '0;
                    if (cpha_q) rx_sh_d = shift_in(rx_sh_q, miso_i);
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        if (!cpha_q) begin
                            mosi_d = first_bit(tx_q);
                            tx_d   = shift_out(tx_q);
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    rx_data_d = rx_sh_q;
                    cs_n_d    = cont_q ? cs_n_q : '1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                accept  = start_i;
            end
            default: state_d = ST_IDLE;
        endcase

        // Accepting a word also releases any CS held from a previous burst
        if (accept) begin
            state_d = ST_SETUP;
            cnt_d   = '0;
            busy_d  = 1'b1;
            cpol_d  = cpol_i;
            cpha_d  = cpha_i;
            cont_d  = cont_i;
            sclk_d  = cpol_i;
            cs_n_d  = cs_decode(cs_sel_i);
            rx_sh_d = '0;
            if (cpha_i) begin
                mosi_d = 1'b1;
                tx_d   = tx_data_i;
            end else begin
                mosi_d = first_bit(tx_data_i);
                tx_d   = shift_out(tx_data_i);
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rx_data_o = rx_data_q;
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign cs_n_o    = cs_n_q;

endmodule

// File: tb/tb_spi_master_p.sv
// Randomised bench for spi_master_p against an edge-driven SPI slave model.
module tb_spi_master_p;

    localparam int unsigned DW   = 8;
    localparam int unsigned CD   = 2;
    localparam int unsigned CSN  = 4;
    localparam int unsigned HOLD = 4;
    localparam int LAT = CD + 2 * CD * DW + HOLD;

    typedef struct packed {
        logic [DW-1:0] tx;
        logic [DW-1:0] sw;
        logic [1:0]    sel;
        logic          pol;
        logic          pha;
        logic          cont;
    } cfg_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [DW-1:0]  tx_in = '0;
    logic [1:0]     sel = '0;
    logic           cpol = 1'b0;
    logic           cpha = 1'b0;
    logic           cont = 1'b0;
    logic           busy, done, sclk, mosi, miso;
    logic [DW-1:0]  rx_data;
    logic [CSN-1:0] cs_n;
    logic           miso_drv = 1'b0;
    bit             lb = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    assign miso = lb ? mosi : miso_drv;

    always #5 clk = ~clk;

    spi_master_p #(
        .DATA_W(DW), .CLK_DIV(CD), .CS_NUM(CSN), .CS_W(2), .HOLD_CYC(HOLD), .LSB_FIRST(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .tx_data_i(tx_in), .cs_sel_i(sel),
        .cpol_i(cpol), .cpha_i(cpha), .cont_i(cont), .busy_o(busy), .done_o(done),
        .rx_data_o(rx_data), .sclk_o(sclk), .mosi_o(mosi), .miso_i(miso), .cs_n_o(cs_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [CSN-1:0] exp_cs(input logic [1:0] s);
        logic [CSN-1:0] v;
        v = '1;
        v[s] = 1'b0;
        return v;
    endfunction

    function automatic cfg_t mk(input logic [DW-1:0] t, input logic [DW-1:0] s, input logic [1:0] cs,
                                input logic p, input logic h, input logic c);
        cfg_t r;
        r.tx = t; r.sw = s; r.sel = cs; r.pol = p; r.pha = h; r.cont = c;
        return r;
    endfunction

    task automatic drive(input cfg_t c);
        start = 1'b1; tx_in = c.tx; sel = c.sel; cpol = c.pol; cpha = c.pha; cont = c.cont;
    endtask

    // Raise start for one cycle; returns at the negedge just after the accepting edge
    task automatic launch(input cfg_t c);
        drive(c);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Slave model plus protocol monitor; returns at the negedge of the done cycle
    task automatic run_word(input cfg_t c, input bit poke, input bit chain, input cfg_t nx);
        int nlead = 0;
        int mbad  = 0;
        int cbad  = 0;
        int sidx  = 0;
        int kdone = -1;
        logic [DW-1:0]  got = '0;
        logic [CSN-1:0] dec;
        logic psclk, pmosi, lead, trail;
        bit seen = 1'b0;
        dec = exp_cs(c.sel);
        check("sclk_at_t0", 32'(sclk), 32'(c.pol));
        psclk = sclk;
        pmosi = mosi;
        if (!c.pha) begin
            miso_drv = c.sw[DW-1];
            sidx = 1;
        end
        for (int k = 0; k <= LAT + 8 && !seen; k++) begin
            if (k > 0) begin
                lead  = (psclk == c.pol) && (sclk != c.pol);
                trail = (psclk != c.pol) && (sclk == c.pol);
                if (lead) nlead++;
                if ((lead && !c.pha) || (trail && c.pha)) got = {got[DW-2:0], mosi};
                if (((trail && !c.pha) || (lead && c.pha)) && sidx < int'(DW)) begin
                    miso_drv = c.sw[DW-1-sidx];
                    sidx++;
                end
                if (mosi != pmosi && !(c.pha ? lead : trail)) mbad++;
                psclk = sclk;
                pmosi = mosi;
            end
            if (done) begin
                seen  = 1'b1;
                kdone = k;
                if (cs_n != (c.cont ? dec : {CSN{1'b1}})) cbad++;
                if (busy) cbad++;
            end else begin
                if (cs_n != dec || !busy) cbad++;
                if (poke && k == 10) begin
                    start = 1'b1;
                    tx_in = 8'hFF;
                end
                if (poke && k == 11) start = 1'b0;
                @(negedge clk);
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(kdone), 32'(LAT));
        check("rx_data", 32'(rx_data), 32'(c.sw));
        check("slave_rx", 32'(got), 32'(c.tx));
        check("lead_edges", 32'(nlead), 32'(DW));
        check("mosi_timing", 32'(mbad), 32'd0);
        check("cs_busy", 32'(cbad), 32'd0);
        if (chain) drive(nx);
    endtask

    task automatic post_idle(input logic pol);
        @(negedge clk);
        check("idle_sclk", 32'(sclk), 32'(pol));
        check("done_pulse", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        cfg_t a, b;
        int bad;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rx", 32'(rx_data), 32'd0);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd1);
        check("rst_cs", 32'(cs_n), 32'hF);
        rst = 1'b0;
        @(negedge clk);

        // Mode 0 loopback
        lb = 1'b1;
        a = mk(8'hA5, 8'hA5, 2'd0, 1'b0, 1'b0, 1'b0);
        launch(a); run_word(a, 1'b0, 1'b0, a); post_idle(1'b0);
        lb = 1'b0;

        // Mode 3 against the slave model
        a = mk(8'h3C, 8'hC3, 2'd0, 1'b1, 1'b1, 1'b0);
        launch(a); run_word(a, 1'b0, 1'b0, a); post_idle(1'b1);

        // cs_sel=2, ignored start mid-word, then back-to-back word started in the done cycle
        a = mk(8'h5A, 8'h96, 2'd2, 1'b0, 1'b0, 1'b0);
        b = mk(8'hE1, 8'h1E, 2'd1, 1'b1, 1'b0, 1'b0);
        launch(a); run_word(a, 1'b1, 1'b1, b);
        @(negedge clk); start = 1'b0;
        run_word(b, 1'b0, 1'b0, b); post_idle(1'b1);

        // Burst: CS held across an idle gap until the cont=0 word completes
        a = mk(8'h12, 8'h77, 2'd0, 1'b0, 1'b1, 1'b1);
        b = mk(8'h34, 8'h88, 2'd0, 1'b0, 1'b1, 1'b0);
        launch(a); run_word(a, 1'b0, 1'b0, a);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cs_n != 4'b1110) bad++;
        end
        check("burst_gap_cs", 32'(bad), 32'd0);
        launch(b); run_word(b, 1'b0, 1'b0, b); post_idle(1'b0);
        check("burst_end_cs", 32'(cs_n), 32'hF);

        // Reset in the middle of a mode-3 word
        a = mk(8'hC6, 8'h39, 2'd3, 1'b1, 1'b1, 1'b0);
        launch(a);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_cs", 32'(cs_n), 32'hF);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sclk", 32'(sclk), 32'd0);
        check("mid_rst_mosi", 32'(mosi), 32'd1);
        check("mid_rst_rx", 32'(rx_data), 32'd0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) bad++;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) bad++;
        end
        check("mid_rst_no_done", 32'(bad), 32'd0);
        a = mk(8'h81, 8'h42, 2'd1, 1'b0, 1'b1, 1'b0);
        launch(a); run_word(a, 1'b0, 1'b0, a); post_idle(1'b0);

        // Randomised words across all modes and selects
        for (int i = 0; i < 12; i++) begin
            a = mk(DW'($urandom), DW'($urandom), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            launch(a); run_word(a, 1'b0, 1'b0, a); post_idle(a.pol);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_master_p.md
Name: spi_master_p

Overview:
Parametrised SPI master that generalises the team's fixed 8-bit, transmit-only SPI controller. It adds configurable word width, clock divider, chip-select count and hold time, runtime-selectable CPOL/CPHA mode, full-duplex MISO capture, and an optional CS-held burst mode. It sits between display/peripheral sequencer FSMs and the board SPI pins, using a start/busy/done handshake.

Parameters:
DATA_W, 8, bits per transfer word (>=2)
CLK_DIV, 16, clk cycles per SCLK half-period (>=1)
CS_NUM, 1, number of chip-select lines (>=1)
CS_W, 1, width of cs_sel (>= clog2(CS_NUM), min 1)
HOLD_CYC, 4, clk cycles CS stays low after last SCLK edge (>=1)
LSB_FIRST, 0, 0 = MSB shifted first, 1 = LSB first

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  request transfer; accepted on a clk edge when busy=0
tx_data  in  DATA_W  word to send, latched on accept
cs_sel  in  CS_W  target slave index, latched on accept
cpol  in  1  SCLK idle level, latched on accept
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on accept
cont  in  1  1 = keep CS low after done (burst), latched on accept
busy  out  1  high from accept until done cycle (exclusive)
done  out  1  one-cycle pulse, rx_data valid
rx_data  out  DATA_W  received word, holds until next done
sclk  out  1  SPI clock
mosi  out  1  serial data out
miso  in  1  serial data in
cs_n  out  CS_NUM  active-low chip selects

Behaviour:
- Reset: state IDLE; busy=0, done=0, rx_data=0, sclk=0, mosi=1, cs_n all 1; latched cpol=0. Reset mid-transfer aborts immediately with these values; no done pulse is issued.
- All outputs are registered.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
- IDLE: sclk=latched cpol. On start=1 at edge T0, latch inputs, set busy=1, drive cs_n[sel]=0 (others 1), enter SETUP.
  - cs_sel >= CS_NUM: transfer runs normally with all cs_n high.
- SETUP: lasts CLK_DIV cycles.
  - cpha=0: mosi = first bit from T0.
  - cpha=1: mosi held at 1 in SETUP.
- SHIFT: DATA_W bits, each 2*CLK_DIV cycles.
  - Leading SCLK edge at CLK_DIV cycles into the bit; trailing edge at 2*CLK_DIV. sclk toggles only in SHIFT.
  - cpha=0: sample miso on leading edge; drive next bit on trailing edge (except after last bit).
  - cpha=1: drive bit on leading edge; sample on trailing edge.
  - Exactly DATA_W sample events per word; sclk returns to cpol after the final trailing edge.
- HOLD: HOLD_CYC cycles; sclk=cpol; mosi holds last bit.
- DONE: lasts 1 cycle.
  - done=1, busy=0, rx_data updated.
  - cs_n all 1 unless cont=1, in which case cs_n[sel] stays 0.
  - Next cycle returns to IDLE.
- Latency: done is high in cycle T0 + CLK_DIV + 2*CLK_DIV*DATA_W + HOLD_CYC.
- start while busy=1 is ignored (not queued). start during the DONE cycle is accepted, giving back-to-back words.
- Burst: with cont=1, cs_n[sel] stays low through IDLE until a transfer with cont=0 completes.
  - A new accept with a different cs_sel first releases the old CS, asserting only the new one from T0.
- After a mode change, sclk moves to the new cpol at T0 and the first edge obeys SETUP timing.

Test Plan:
- DATA_W=8, CLK_DIV=2, HOLD_CYC=4, mode 0, miso looped to mosi, tx=0xA5 -> rx_data=0xA5; done at T0+38; 8 rising sclk edges; sclk idle 0.
- Mode 3 (cpol=1, cpha=1), tx=0x3C, slave model returns 0xC3 -> sclk idle 1, mosi changes on falling edges, rx_data=0xC3.
- CS_NUM=4, cs_sel=2 -> only cs_n[2] low from T0 to the done cycle; cs_n[0,1,3] stay 1 throughout.
- start re-asserted at T0+10 with tx=0xFF -> ignored; rx/tx of the first word unaffected; start in the done cycle -> second word accepted with no idle gap.
- cont=1 then cont=0 for two words (0x12, 0x34) -> cs_n[0] low continuously across both; high only after the second done.
- rst asserted at T0+15 -> cs_n=all 1, busy=0, sclk=0, mosi=1 immediately; no done; a fresh transfer after release completes correctly.
